// File: rtl/pako_pkg.sv
// Shared types and constants for the mem_data load/store front-end.
//   mem_size_t        : access size as carried through the controller
//   mem_ctrl_state_t  : controller FSM states
//   LANE_MASK_B/H     : right-aligned byte / halfword lane masks
//   decode_size()     : maps the raw 2-bit size field, 2'b11 folds to word
package pako_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW
  } mem_ctrl_state_t;

  localparam logic [31:0] LANE_MASK_B = 32'h0000_00ff;
  localparam logic [31:0] LANE_MASK_H = 32'h0000_ffff;

  function automatic mem_size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return MEM_B;
      2'b01:   return MEM_H;
      default: return MEM_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_data_lane.sv
// Combinational lane logic shared by the load and read-modify-write paths.
// Ports:
//   old_word_i    : word read from RAM
//   new_data_i    : right-aligned store data
//   size_i        : access size
//   offset_i      : byte offset within the word (addr[1:0])
//   is_unsigned_i : zero-extend loads when 1, sign-extend when 0
//   load_data_o   : extracted and extended load value
//   store_data_o  : old word with only the target lane replaced
module mem_data_lane
  import pako_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_data_i,
  input  mem_size_t   size_i,
  input  logic [1:0]  offset_i,
  input  logic        is_unsigned_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_data_o
);

  logic [4:0]  shamt;
  logic [31:0] mask;
  logic [31:0] lane;
  logic        sign;

  always_comb begin
    shamt        = '0;
    mask         = '0;
    lane         = '0;
    sign         = 1'b0;
    load_data_o  = old_word_i;
    store_data_o = new_data_i;
    case (size_i)
      MEM_B: begin
        shamt = {offset_i, 3'b000};
        mask  = LANE_MASK_B;
      end
      MEM_H: begin
        // Halves select by addr[1] only; addr[0] is ignored here.
        shamt = {offset_i[1], 4'b0000};
        mask  = LANE_MASK_H;
      end
      default: ;
    endcase
    if (size_i != MEM_W) begin
      lane         = (old_word_i >> shamt) & mask;
      sign         = (size_i == MEM_B) ? lane[7] : lane[15];
      load_data_o  = (is_unsigned_i || !sign) ? lane : (lane | ~mask);
      store_data_o = (old_word_i & ~(mask << shamt)) | ((new_data_i & mask) << shamt);
    end
  end

endmodule

// File: rtl/mem_data_ctrl.sv
// Load/store front-end between the execute stage and the dual-port mem_data RAM.
// One request at a time; sub-word stores become read-modify-write.
// Optional feature: define MEM_MISALIGN_CHECK_EN to reject misaligned half/word
// accesses with rsp_err_o instead of touching the RAM.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   req_*                   : request (valid/ready, we, addr, size, unsigned, wdata)
//   rsp_valid_o/rdata/err   : one-cycle response pulse per accepted request
//   mem_r_en_o/addr_r_o     : RAM read port (data on mem_data_r_i one cycle later)
//   mem_wr_en_o/addr_w/data : RAM write port
module mem_data_ctrl
  import pako_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              mem_r_en_o,
  output logic [ADDR_W-1:0] mem_addr_r_o,
  input  logic [31:0]       mem_data_r_i,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_addr_w_o,
  output logic [31:0]       mem_data_w_o
);

  mem_ctrl_state_t   state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  mem_size_t         size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;

  mem_size_t   req_size;
  logic        accept;
  logic        misalign;
  logic        rd_en, wr_en;
  logic [31:0] lane_load, lane_store;

  assign req_size    = decode_size(req_size_i);
  assign req_ready_o = (state_q == ST_IDLE);
  assign accept      = req_valid_i && req_ready_o && !rst_i;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = ((req_size == MEM_H) && req_addr_i[0]) ||
                    ((req_size == MEM_W) && (req_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  mem_data_lane u_lane (
    .old_word_i    (mem_data_r_i),
    .new_data_i    (wdata_q),
    .size_i        (size_q),
    .offset_i      (addr_q[1:0]),
    .is_unsigned_i (uns_q),
    .load_data_o   (lane_load),
    .store_data_o  (lane_store)
  );

  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    mem_addr_w_o = {req_addr_i[ADDR_W-1:2], 2'b00};
    mem_data_w_o = req_wdata_i;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = req_addr_i;
          size_d  = req_size;
          uns_d   = req_unsigned_i;
          wdata_d = req_wdata_i;
          if (misalign) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we_i && (req_size == MEM_W)) begin
            wr_en       = 1'b1;
            rsp_valid_d = 1'b1;
          end else begin
            rd_en   = 1'b1;
            state_d = req_we_i ? ST_RMW : ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = lane_load;
        state_d     = ST_IDLE;
      end
      ST_RMW: begin
        wr_en        = 1'b1;
        mem_addr_w_o = {addr_q[ADDR_W-1:2], 2'b00};
        mem_data_w_o = lane_store;
        rsp_valid_d  = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The RMW write is combinational, so reset must mask it in the same cycle
  // to drop an in-flight operation without touching the RAM.
  assign mem_wr_en_o  = wr_en && !rst_i;
  assign mem_r_en_o   = rd_en;
  assign mem_addr_r_o = {req_addr_i[ADDR_W-1:2], 2'b00};

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      size_q      <= MEM_B;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_data_ctrl.sv
// Scoreboard bench for mem_data_ctrl: the stimulus thread pushes the expected
// response (data, err, due cycle) per request; a negedge monitor pops and
// compares each rsp_valid_o pulse. A small RAM model sits on the memory ports.
module tb_mem_data_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_r_en_o;
  logic [31:0] mem_addr_r_o;
  logic [31:0] mem_data_r_i;
  logic        mem_wr_en_o;
  logic [31:0] mem_addr_w_o;
  logic [31:0] mem_data_w_o;

  always #5 clk = ~clk;

  mem_data_ctrl #(.ADDR_W(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .mem_r_en_o     (mem_r_en_o),
    .mem_addr_r_o   (mem_addr_r_o),
    .mem_data_r_i   (mem_data_r_i),
    .mem_wr_en_o    (mem_wr_en_o),
    .mem_addr_w_o   (mem_addr_w_o),
    .mem_data_w_o   (mem_data_w_o)
  );

  // RAM model: 64 words, one-cycle read latency.
  logic [31:0] ram [0:63];
  initial begin
    for (int i = 0; i < 64; i++) ram[i] = '0;
    mem_data_r_i = '0;
  end
  always @(posedge clk) begin
    if (mem_r_en_o)  mem_data_r_i <= ram[mem_addr_r_o[7:2]];
    if (mem_wr_en_o) ram[mem_addr_w_o[7:2]] <= mem_data_w_o;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned due;
  } exp_t;
  exp_t sb[$];

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (rsp_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h with no request pending (cycle %0d)", rsp_rdata_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata_o, e.data);
        chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, e.err});
        chk("rsp_cycle", cyc, e.due);
      end
    end
  end

  // Present one request, check the accept-cycle RAM enables, queue the response.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd,
                       input logic exp_rd, input logic exp_wr,
                       input bit want_rsp, input logic [31:0] exp_d,
                       input logic exp_e, input int unsigned lat);
    int unsigned guard;
    guard = 0;
    @(negedge clk);
    while (req_ready_o !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (req_ready_o !== 1'b1) begin
      nvec++;
      nfail++;
      $display("FAIL ready_timeout: got ready %b expected 1", req_ready_o);
    end
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_addr_i     = addr;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_wdata_i    = wd;
    #1;
    chk("accept_rd_en", {31'b0, mem_r_en_o}, {31'b0, exp_rd});
    chk("accept_wr_en", {31'b0, mem_wr_en_o}, {31'b0, exp_wr});
    if (exp_wr) begin
      chk("word_wdata", mem_data_w_o, wd);
      chk("word_waddr", mem_addr_w_o, {addr[31:2], 2'b00});
    end
    if (exp_rd) chk("read_addr", mem_addr_r_o, {addr[31:2], 2'b00});
    if (want_rsp) sb.push_back('{exp_d, exp_e, cyc + lat});
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  // Called right after issue() of a sub-word store: checks the merge write.
  task automatic check_rmw(input logic [31:0] exp_data, input logic [31:0] exp_addr);
    @(negedge clk);
    #1;
    chk("rmw_wr_en", {31'b0, mem_wr_en_o}, 32'd1);
    chk("rmw_wdata", mem_data_w_o, exp_data);
    chk("rmw_waddr", mem_addr_w_o, exp_addr);
  endtask

  initial begin
    int unsigned guard;
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_we_i = 1'b0;
    req_addr_i = '0;
    req_size_i = '0;
    req_unsigned_i = 1'b0;
    req_wdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("reset_rsp_err", {31'b0, rsp_err_o}, 32'd0);
    chk("reset_wr_en", {31'b0, mem_wr_en_o}, 32'd0);
    chk("reset_rd_en", {31'b0, mem_r_en_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'b0, req_ready_o}, 32'd1);

    // Word store then word load.
    issue(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1);
    issue(1'b0, 32'h10, 2'b10, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 2);

    // Byte store RMW over 0x11223344.
    issue(1'b1, 32'h10, 2'b10, 1'b0, 32'h11223344, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1);
    issue(1'b1, 32'h11, 2'b00, 1'b0, 32'h000000AA, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 2);
    check_rmw(32'h1122AA44, 32'h10);
    issue(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1122AA44, 1'b0, 2);

    // Byte loads, signed and unsigned.
    issue(1'b1, 32'h20, 2'b10, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1);
    issue(1'b0, 32'h23, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0, 2);
    issue(1'b0, 32'h23, 2'b00, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 32'h00000080, 1'b0, 2);

    // Half loads and a half store.
    issue(1'b1, 32'h30, 2'b10, 1'b0, 32'h8001FFFF, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1);
    issue(1'b0, 32'h32, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hFFFF8001, 1'b0, 2);
    issue(1'b0, 32'h30, 2'b01, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000FFFF, 1'b0, 2);
    issue(1'b1, 32'h32, 2'b01, 1'b0, 32'hABCD1234, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 2);
    check_rmw(32'h1234FFFF, 32'h30);
    issue(1'b0, 32'h30, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1234FFFF, 1'b0, 2);

    // Reset during RMW: write masked, no response, RAM unchanged.
    issue(1'b1, 32'h40, 2'b10, 1'b0, 32'h55667788, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1);
    issue(1'b1, 32'h40, 2'b00, 1'b0, 32'h00000099, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("rmw_reset_wr_en", {31'b0, mem_wr_en_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", {31'b0, req_ready_o}, 32'd1);
    issue(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h55667788, 1'b0, 2);

    // Misaligned word and half.
    issue(1'b1, 32'h00, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1);
`ifdef MEM_MISALIGN_CHECK_EN
    issue(1'b0, 32'h02, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1);
    issue(1'b0, 32'h11, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1);
`else
    issue(1'b0, 32'h02, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 2);
    issue(1'b0, 32'h11, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hFFFFAA44, 1'b0, 2);
`endif

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk("pending_rsp", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
